// File: rtl/rede_io_pkg.sv
// rede_io_pkg: shared widths, constants and types for the rede_float host I/O server
// Ports: none (package only).
package rede_io_pkg;
  localparam int N_CORES = 4;
  localparam int CORE_W = $clog2(N_CORES);
  localparam int IN_W = 19;
  localparam int OUT_W = 28;
  localparam int REQ_W = 4;
  localparam logic [REQ_W-1:0] REQ_IDLE = '0;
  typedef enum logic {SEQ, DONE} seq_e;
  typedef struct packed {
    logic [OUT_W-1:0] value;
    logic [CORE_W-1:0] core;
    logic [REQ_W-1:0] tag;
  } entry_t;
endpackage

// File: rtl/rede_io_server_rr_arb.sv
// rr_arb: N-way round-robin arbiter whose search starts at the core after the last winner
// Ports: i_clk/i_rst_n clock and async active-low reset; i_req eligibility mask;
//        i_adv advances the pointer past the winner; o_valid/o_idx winner.
module rr_arb #(
  parameter int N = 4,
  localparam int W = $clog2(N)
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [N-1:0] i_req,
  input  logic         i_adv,
  output logic         o_valid,
  output logic [W-1:0] o_idx
);
  logic [W-1:0] r_ptr;
  logic [W-1:0] w_j;
  // scanning from lowest priority to highest lets the last hit be the winner
  always_comb begin
    o_valid = 1'b0;
    o_idx = '0;
    w_j = '0;
    for (int i = N - 1; i >= 0; i--) begin
      w_j = W'((int'(r_ptr) + i) % N);
      if (i_req[w_j]) begin
        o_valid = 1'b1;
        o_idx = w_j;
      end
    end
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_ptr <= '0;
    else if (i_adv && o_valid) r_ptr <= (o_idx == W'(N - 1)) ? '0 : o_idx + 1'b1;
endmodule

// File: rtl/rede_io_server.sv
// rede_io_server: staggered core reset release, channel-bank input service and result collection FIFO
// Ports: i_clk/i_rst_n clock and async active-low reset; o_core_rst per-core reset;
//        i_bank_* channel bank write; i_core_req/o_io_in/o_core_gnt input service;
//        i_core_out/i_core_out_en results; o_m_* result stream; o_overflow/o_drop_cnt drop status.
module rede_io_server #(
  parameter int N_CORES = rede_io_pkg::N_CORES,
  parameter int IN_W = rede_io_pkg::IN_W,
  parameter int OUT_W = rede_io_pkg::OUT_W,
  parameter int FIFO_DEPTH = 8,
  parameter int RST_GAP = 13,
  localparam int CW = $clog2(N_CORES)
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  output logic [N_CORES-1:0]       o_core_rst,
  input  logic                     i_bank_we,
  input  logic [3:0]               i_bank_addr,
  input  logic [IN_W-1:0]          i_bank_data,
  input  logic [4*N_CORES-1:0]     i_core_req,
  output logic signed [IN_W-1:0]   o_io_in,
  output logic [N_CORES-1:0]       o_core_gnt,
  input  logic [OUT_W*N_CORES-1:0] i_core_out,
  input  logic [4*N_CORES-1:0]     i_core_out_en,
  output logic                     o_m_valid,
  input  logic                     i_m_ready,
  output logic [OUT_W-1:0]         o_m_data,
  output logic [CW-1:0]            o_m_core,
  output logic [3:0]               o_m_tag,
  output logic                     o_overflow,
  output logic [7:0]               o_drop_cnt
);
  import rede_io_pkg::*;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int DW = CW + 1;
  localparam int GW = $clog2(RST_GAP + 1);
  seq_e r_state, w_state_nx;
  logic [CW-1:0] r_k, w_k_nx;
  logic [GW-1:0] r_cnt, w_cnt_nx;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_state <= SEQ;
      r_k <= '0;
      r_cnt <= '0;
    end else begin
      r_state <= w_state_nx;
      r_k <= w_k_nx;
      r_cnt <= w_cnt_nx;
    end
  // r_k is the next core to release; it is released on the edge where r_cnt is zero
  always_comb begin
    w_state_nx = r_state;
    w_k_nx = r_k;
    w_cnt_nx = r_cnt;
    if (r_state == SEQ) begin
      if (r_cnt != '0) w_cnt_nx = r_cnt - 1'b1;
      else if (r_k == CW'(N_CORES - 1)) w_state_nx = DONE;
      else begin
        w_k_nx = r_k + 1'b1;
        w_cnt_nx = GW'(RST_GAP - 1);
      end
    end
  end
  always_comb begin
    o_core_rst = '1;
    for (int i = 0; i < N_CORES; i++) o_core_rst[i] = !(r_state == DONE || r_k > CW'(i));
  end
  logic [N_CORES-1:0] w_in_req, r_gnt;
  logic w_in_valid;
  logic [CW-1:0] w_in_idx;
  logic [REQ_W-1:0] w_ch;
  logic [IN_W-1:0] r_bank [16];
  logic [IN_W-1:0] w_rd, r_io;
  // the core granted this cycle sits out, so no core wins twice in a row
  always_comb begin
    w_in_req = '0;
    for (int i = 0; i < N_CORES; i++)
      w_in_req[i] = i_core_req[REQ_W*i +: REQ_W] != REQ_IDLE && !o_core_rst[i] && !r_gnt[i];
  end
  rr_arb #(.N(N_CORES)) u_in_arb (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_req(w_in_req), .i_adv(1'b1),
    .o_valid(w_in_valid), .o_idx(w_in_idx)
  );
  assign w_ch = i_core_req[REQ_W*w_in_idx +: REQ_W];
  assign w_rd = (i_bank_we && i_bank_addr == w_ch) ? i_bank_data : r_bank[w_ch];
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      for (int b = 0; b < 16; b++) r_bank[b] <= '0;
      r_gnt <= '0;
      r_io <= '0;
    end else begin
      if (i_bank_we && i_bank_addr != REQ_IDLE) r_bank[i_bank_addr] <= i_bank_data;
      r_gnt <= w_in_valid ? N_CORES'(1) << w_in_idx : '0;
      if (w_in_valid) r_io <= w_rd;
    end
  assign o_io_in = r_io;
  assign o_core_gnt = r_gnt;
  logic [N_CORES-1:0] r_pv, w_en, w_drain, w_drop;
  logic [OUT_W-1:0] r_pval [N_CORES];
  logic [REQ_W-1:0] r_ptag [N_CORES];
  logic w_dr_valid, w_push, w_pop, w_full, w_empty, r_ovf;
  logic [CW-1:0] w_dr_idx;
  logic [DW-1:0] w_ndrop;
  logic [8:0] w_drop_sum;
  logic [7:0] r_drop;
  // a pending slot being drained this cycle can accept a new result without a drop
  always_comb begin
    w_en = '0;
    w_drain = '0;
    w_drop = '0;
    w_ndrop = '0;
    for (int i = 0; i < N_CORES; i++) begin
      w_en[i] = i_core_out_en[REQ_W*i +: REQ_W] != REQ_IDLE && !o_core_rst[i];
      w_drain[i] = w_push && w_dr_idx == CW'(i);
      w_drop[i] = w_en[i] && r_pv[i] && !w_drain[i];
      w_ndrop = w_ndrop + DW'(w_drop[i]);
    end
  end
  assign w_drop_sum = 9'(r_drop) + 9'(w_ndrop);
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_pv <= '0;
      r_ovf <= 1'b0;
      r_drop <= '0;
      for (int i = 0; i < N_CORES; i++) begin
        r_pval[i] <= '0;
        r_ptag[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_CORES; i++)
        if (w_en[i] && !w_drop[i]) begin
          r_pv[i] <= 1'b1;
          r_pval[i] <= i_core_out[OUT_W*i +: OUT_W];
          r_ptag[i] <= i_core_out_en[REQ_W*i +: REQ_W];
        end else if (w_drain[i]) r_pv[i] <= 1'b0;
      if (|w_drop) r_ovf <= 1'b1;
      r_drop <= w_drop_sum[8] ? 8'hFF : w_drop_sum[7:0];
    end
  rr_arb #(.N(N_CORES)) u_out_arb (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_req(r_pv), .i_adv(w_push),
    .o_valid(w_dr_valid), .o_idx(w_dr_idx)
  );
  // pointers carry one extra wrap bit to tell full from empty
  logic [AW:0] r_wp, r_rp;
  entry_t r_mem [FIFO_DEPTH];
  entry_t w_head;
  assign w_empty = r_wp == r_rp;
  assign w_full = r_wp == {~r_rp[AW], r_rp[AW-1:0]};
  assign w_pop = !w_empty && i_m_ready;
  assign w_push = w_dr_valid && (!w_full || w_pop);
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop) r_rp <= r_rp + 1'b1;
    end
  always_ff @(posedge i_clk)
    if (w_push) r_mem[r_wp[AW-1:0]] <= '{value: r_pval[w_dr_idx], core: w_dr_idx, tag: r_ptag[w_dr_idx]};
  assign w_head = r_mem[r_rp[AW-1:0]];
  assign o_m_valid = !w_empty;
  assign o_m_data = w_head.value;
  assign o_m_core = w_head.core;
  assign o_m_tag = w_head.tag;
  assign o_overflow = r_ovf;
  assign o_drop_cnt = r_drop;
endmodule

// File: doc/rede_io_server.md
# rede_io_server

Host-side counterpart of the multicore `rede_float` array: it serves the cores' input requests and collects their results. It releases per-core resets in a staggered sequence. It answers each core's `req_in` channel request by driving the shared `io_in` bus from a host-written channel bank, with a one-hot grant. It captures every core's `io_out`/`out_en` pulse into a tagged output FIFO that the host drains over a valid/ready stream.

## Interface
- `N_CORES`, 4: number of cores served; must be ≥2.
- `IN_W`, 19: width of `io_in` and the channel bank.
- `OUT_W`, 28: width of core results.
- `FIFO_DEPTH`, 8: output FIFO entries; must be a power of 2.
- `RST_GAP`, 13: cycles between successive core reset releases.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `core_rst` out N_CORES: active-high reset to each core.
- `bank_we` in 1: host write strobe for the channel bank.
- `bank_addr` in 4: channel number. Writes to channel 0 are ignored.
- `bank_data` in IN_W: channel value.
- `core_req` in 4·N_CORES: packed `req_in` codes; core i uses bits [4i+3:4i]. Code 0 = idle, codes 1..15 = channel number.
- `io_in` out IN_W, signed: shared input bus to all cores.
- `core_gnt` out N_CORES: one-hot grant qualifying `io_in`.
- `core_out` in OUT_W·N_CORES: packed `io_out`.
- `core_out_en` in 4·N_CORES: packed `out_en`. A nonzero code is a one-cycle result pulse.
- `m_valid` out 1, `m_ready` in 1: output stream handshake.
- `m_data` out OUT_W: result value.
- `m_core` out $clog2(N_CORES): index of the core that produced the result.
- `m_tag` out 4: `out_en` code of the result.
- `overflow` out 1: sticky; set when any result is dropped.
- `drop_cnt` out 8: count of dropped results; saturates at 255.

## Operation
- **Reset values:** `core_rst` all ones; `core_gnt`, `io_in`, `m_valid`, `overflow`, `drop_cnt` all 0. Channel bank cleared, FIFO empty, all pending bits clear, both arbiter pointers at core 0.
- **Reset sequencer:** states `SEQ(k)` for k = 0..N_CORES-1, then `DONE`.
  - `core_rst[0]` falls on the first edge after `rst` deasserts.
  - `core_rst[k]` falls exactly `RST_GAP` cycles after `core_rst[k-1]`.
  - `DONE` is terminal.
  - A core whose `core_rst` is high is masked from both arbiters.
- **Input service:**
  - Each cycle, round-robin arbitration among unmasked cores with `core_req ≠ 0`. Search starts after the last granted core.
  - The winner gets a registered `core_gnt` bit, and `io_in` is loaded with the bank entry selected by the winner's req code.
  - A core granted in the current cycle is excluded from this cycle's arbitration, so the same core is never granted on consecutive cycles.
  - With no winner: `core_gnt` = 0 and `io_in` holds its last value.
  - A bank write to the channel being read on the same edge passes through: `io_in` takes the new `bank_data`.
- **Output capture:**
  - Each core has a one-deep pending register holding value and tag.
  - A nonzero `out_en` from an unmasked core loads its pending register.
  - If that core's pending bit is already set and is not being drained this cycle, the new result is dropped: `overflow` is set and `drop_cnt` increments.
  - If the pending entry is drained in the same cycle a new pulse arrives, the new result is captured with no drop.
- **Drain:**
  - A round-robin arbiter moves one pending entry per cycle into the FIFO when the FIFO is not full.
  - A push into a full FIFO is allowed when a pop happens in the same cycle.
- **FIFO:** first-word-fall-through. `m_valid` = not empty. The head entry is popped on `m_valid && m_ready`.
- **Reset mid-operation:** `rst` low immediately forces every reset value, discarding pending and FIFO contents. The reset sequence restarts from `SEQ(0)`.

## Timing
- **Request to grant:** request present in cycle t → `core_gnt` and `io_in` valid in cycle t+1, for exactly one cycle.
- **Result to stream:** `out_en` pulse in cycle t → pending set at t+1 → `m_valid` earliest in cycle t+2.
- **Drain throughput:** 1 result per cycle with `m_ready` held high.
- **Core release time:** core k leaves reset at edge 1 + k·`RST_GAP` after `rst` deasserts.

## Structure
- **Shared package `rede_io_pkg`:**
  - `IN_W`, `OUT_W`, `REQ_W = 4`.
  - `REQ_IDLE = 0`.
  - Result entry struct: value, core index, tag.
- **Sub-module `rr_arb`:** N-way round-robin arbiter with eligibility mask and pointer update on grant. Instantiated twice, once for input service and once for output drain.
- **Inline logic:** FIFO, channel bank and reset sequencer.

## Test plan
- **Reset sequence:** N_CORES=4, RST_GAP=13, release `rst` → `core_rst` = 4'b1111 during reset; bits fall at edges 1, 14, 27, 40.
- **Single request:** after `DONE`, write bank[3] = 19'h12345; core1 drives req=3 in cycle t → cycle t+1 shows `core_gnt` = 4'b0010 and `io_in` = 19'h12345.
- **Contention and masking:**
  - Cores 0 and 2 hold req=1 → grants alternate 0, 2, 0, 2, starting with core 0; never the same core on consecutive cycles.
  - A still-reset core requesting is never granted.
- **Simultaneous results:** cores 0, 1, 3 pulse `out_en` = 1 in the same cycle with values 100, 200, 300, `m_ready` = 1 → stream outputs (m_core, m_data) = (0,100), (1,200), (3,300) in cycles t+2, t+3, t+4.
- **Overflow:** `m_ready` = 0, fill the FIFO with 8 results, then core2 pulses twice → first result held pending, second dropped; `overflow` = 1, `drop_cnt` = 1. Raising `m_ready` drains 9 entries.
- **Mid-operation reset:** assert `rst` low while the FIFO is non-empty and a grant is active → `m_valid`, `core_gnt` and `io_in` go to 0 and `core_rst` goes to all ones without waiting for a clock edge; the sequence restarts on release.
